// File: rtl/fb_scanline_fetcher.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fb_scanline_fetcher
//
// Framebuffer scan-out controller for the 640x480 DVI path. RGB565 scanlines
// are read from shared memory over a valid/ready bus into a two-bank line
// buffer. The buffer is then read out as 24-bit RGB for the DVI generator.
// Line L always lives in bank L[0]. When the generator finishes line y, line
// y+2 is fetched into the bank that line y has just released.
//
// Ports
//   clk_pixel  in   1   pixel clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   enable     in   1   scan-out enable; black output while low
//   fb_base    in   32  byte address of line 0, sampled on frame_end
//   xpos       in   10  generator pixel column
//   ypos       in   10  generator line
//   line_end   in   1   last visible pixel of line ypos
//   frame_end  in   1   last visible pixel of the frame
//   mem_valid  out  1   read request, held until accepted
//   mem_addr   out  32  word-aligned byte address, stable while waiting
//   mem_ready  in   1   request accepted, mem_rdata valid this cycle
//   mem_rdata  in   32  read data (two RGB565 pixels, even pixel in [15:0])
//   rgb_data   out  24  {R8,G8,B8}, one cycle after xpos/ypos
//   underrun   out  1   sticky: a fetch was still running when the next one
//                       was needed
// ---------------------------------------------------------------------------
module fb_scanline_fetcher #(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int WORDS_LINE = 320,
    parameter int LINE_BYTES = 1280
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] fb_base,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    input  logic        line_end,
    input  logic        frame_end,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [23:0] rgb_data,
    output logic        underrun
);

    localparam logic [31:0] STRIDE    = 32'(LINE_BYTES);
    localparam logic [8:0]  LAST_WORD = 9'(WORDS_LINE - 1);
    localparam logic [10:0] V_LIMIT11 = 11'(V_LINES);
    localparam logic [9:0]  V_LIMIT   = 10'(V_LINES);
    localparam logic [9:0]  H_LIMIT   = 10'(H_PIXELS);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t      state;
    logic [31:0] base;        // line 0 address of the current frame
    logic [31:0] next_addr;   // address of the line the next line_end fetches
    logic [8:0]  word_idx;
    logic        bank;
    logic        chain;       // line 1 follows once line 0 is complete
    logic        frame_ok;

    // A trigger that arrives while a beat is still outstanding is parked here
    // until that beat completes.
    logic        pend;
    logic [31:0] pend_addr;
    logic        pend_bank;
    logic        pend_chain;

    logic [31:0] line_buf [2][WORDS_LINE];

    logic        fe_trig;
    logic        le_trig;
    logic        trig;
    logic [31:0] trig_addr;
    logic        trig_bank;
    logic        beat;
    logic        last_beat;
    logic        load_new;
    logic [31:0] new_addr;
    logic        new_bank;
    logic        new_chain;

    // NOTE: every signal in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        fe_trig   = enable & frame_end;
        // frame_end wins over a coincident line_end; lines past the bottom
        // of the frame are not fetched.
        le_trig   = enable & line_end & ~frame_end &
                    (({1'b0, ypos} + 11'd2) < V_LIMIT11);
        trig      = fe_trig | le_trig;
        trig_addr = fe_trig ? fb_base : next_addr;
        trig_bank = fe_trig ? 1'b0 : ypos[0];
        beat      = mem_valid & mem_ready;
        last_beat = beat & (word_idx == LAST_WORD);

        load_new  = 1'b0;
        new_addr  = trig_addr;
        new_bank  = trig_bank;
        new_chain = fe_trig;
        if (state == IDLE) begin
            load_new = trig;
        end else if (beat) begin
            if (trig) begin
                load_new = 1'b1;
            end else if (pend) begin
                load_new  = 1'b1;
                new_addr  = pend_addr;
                new_bank  = pend_bank;
                new_chain = pend_chain;
            end else if (last_beat && chain && enable) begin
                load_new  = 1'b1;
                new_addr  = base + STRIDE;
                new_bank  = 1'b1;
                new_chain = 1'b0;
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            word_idx   <= '0;
            bank       <= 1'b0;
            chain      <= 1'b0;
            base       <= '0;
            next_addr  <= '0;
            frame_ok   <= 1'b0;
            underrun   <= 1'b0;
            pend       <= 1'b0;
            pend_addr  <= '0;
            pend_bank  <= 1'b0;
            pend_chain <= 1'b0;
        end else begin
            if (!enable) begin
                frame_ok <= 1'b0;
            end else if (fe_trig) begin
                frame_ok <= 1'b1;
            end

            // Running line address: lines 0 and 1 are fetched at frame_end,
            // so the first line_end of the frame fetches line 2.
            if (fe_trig) begin
                base      <= fb_base;
                next_addr <= fb_base + (STRIDE << 1);
            end else if (enable && line_end) begin
                next_addr <= next_addr + STRIDE;
            end

            // Finishing the last beat of the last queued line on the same
            // edge as a new trigger is a clean hand-over, not an underrun.
            if (state == FETCH && trig && !(last_beat && !chain)) begin
                underrun <= 1'b1;
            end

            if (load_new) begin
                state     <= FETCH;
                mem_valid <= 1'b1;
                mem_addr  <= new_addr;
                word_idx  <= '0;
                bank      <= new_bank;
                chain     <= new_chain;
                pend      <= 1'b0;
            end else if (beat) begin
                if (last_beat) begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                    chain     <= 1'b0;
                end else begin
                    mem_addr <= mem_addr + 32'd4;
                    word_idx <= word_idx + 9'd1;
                end
            end else if (state == FETCH && trig) begin
                // Bus is mid-beat: keep address stable, restart afterwards.
                pend       <= 1'b1;
                pend_addr  <= trig_addr;
                pend_bank  <= trig_bank;
                pend_chain <= fe_trig;
            end
        end
    end

    // NOTE: the line buffer has no reset; its contents are only shown after a
    // frame_end refill, and a resettable array could not map onto RAM.
    always_ff @(posedge clk_pixel) begin
        if (beat) begin
            line_buf[bank][word_idx] <= mem_rdata;
        end
    end

    logic        pix_on;
    logic [31:0] rd_word;
    logic [15:0] pix;

    always_comb begin
        pix_on  = enable & frame_ok & (xpos < H_LIMIT) & (ypos < V_LIMIT);
        rd_word = '0;
        if (pix_on) begin
            rd_word = line_buf[ypos[0]][xpos[9:1]];
        end
        pix = xpos[0] ? rd_word[31:16] : rd_word[15:0];
    end

    // RGB565 -> RGB888 by replicating the top bits into the low bits.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            rgb_data <= '0;
        end else if (pix_on) begin
            rgb_data <= {pix[15:11], pix[15:13],
                         pix[10:5],  pix[10:9],
                         pix[4:0],   pix[4:2]};
        end else begin
            rgb_data <= '0;
        end
    end

endmodule
